// File: rtl/pu_slave_spi_rx_bank_if.sv
// Bus between the SPI splitter/NITTA side and the receive double buffer.
// The master drives words, frame/cycle pulses and the read strobe; the slave returns read data and status.
interface pu_slave_spi_rx_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int CNT_W      = 3
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  frame_end;
  logic                  signal_cycle;
  logic                  oe;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ATTR_WIDTH-1:0] attr_out;
  logic [CNT_W-1:0]      words_ready;

  modport master (
    output wr, data_in, frame_end, signal_cycle, oe,
    input  data_out, attr_out, words_ready
  );

  modport slave (
    input  wr, data_in, frame_end, signal_cycle, oe,
    output data_out, attr_out, words_ready
  );
endinterface

// File: rtl/pu_slave_spi_rx_bank.sv
// Receive-side double buffer: fills a write bank from the SPI splitter and swaps it to NITTA at a cycle boundary.
// Optional SPI_RX_STATUS_WORD_EN: read slot 0 returns {rovf, zero pad, rcnt} ahead of the data words.
module pu_slave_spi_rx_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int BUF_SIZE   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  pu_slave_spi_rx_bank_if.slave bus
);
  localparam int CNT_W = $clog2(BUF_SIZE + 1);
  localparam int RP_W  = $clog2(BUF_SIZE + 2);
  localparam int AW    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

  logic                  wsel_q, wsel_d;
  logic [CNT_W-1:0]      wp_q, wp_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic [RP_W-1:0]       rp_q, rp_d;
  logic                  pend_q, pend_d;
  logic                  wovf_q, wovf_d;
  logic                  rovf_q, rovf_d;
  logic [DATA_WIDTH-1:0] mem_q [0:1][0:BUF_SIZE-1];

  logic                  swap;
  logic                  mem_we;
  logic                  mem_wsel;
  logic [AW-1:0]         mem_waddr;
  logic [RP_W-1:0]       rd_limit;
  logic                  rd_valid;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  // A frame_end arriving together with signal_cycle still hands the frame over in that clock.
  assign swap = bus.signal_cycle && (pend_q || bus.frame_end);

`ifdef SPI_RX_STATUS_WORD_EN
  logic [DATA_WIDTH-1:0] status_word;

  always_comb begin
    status_word                 = '0;
    status_word[DATA_WIDTH-1]   = rovf_q;
    status_word[CNT_W-1:0]      = rcnt_q;
  end

  assign rd_limit = RP_W'(rcnt_q) + RP_W'(1);
  assign rd_addr  = AW'(rp_q - RP_W'(1));
  assign rd_word  = (rp_q == '0) ? status_word : mem_q[~wsel_q][rd_addr];
`else
  assign rd_limit = RP_W'(rcnt_q);
  assign rd_addr  = AW'(rp_q);
  assign rd_word  = mem_q[~wsel_q][rd_addr];
`endif

  assign rd_valid = rp_q < rd_limit;

  always_comb begin
    wsel_d    = wsel_q;
    wp_d      = wp_q;
    rcnt_d    = rcnt_q;
    rp_d      = rp_q;
    pend_d    = pend_q;
    wovf_d    = wovf_q;
    rovf_d    = rovf_q;
    mem_we    = 1'b0;
    mem_wsel  = wsel_q;
    mem_waddr = AW'(wp_q);

    if (bus.oe && rd_valid) rp_d = rp_q + RP_W'(1);
    if (bus.signal_cycle)   rp_d = '0;

    if (swap) begin
      wsel_d    = ~wsel_q;
      rcnt_d    = wp_q;
      rovf_d    = wovf_q;
      wovf_d    = 1'b0;
      pend_d    = 1'b0;
      // A word in the swap clock opens the next frame in the freshly freed bank.
      wp_d      = bus.wr ? CNT_W'(1) : '0;
      mem_we    = bus.wr;
      mem_wsel  = ~wsel_q;
      mem_waddr = '0;
    end else begin
      if (bus.frame_end) pend_d = 1'b1;
      if (bus.wr) begin
        if (wp_q < CNT_W'(BUF_SIZE)) begin
          mem_we = 1'b1;
          wp_d   = wp_q + CNT_W'(1);
        end else begin
          wovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_q <= 1'b0;
      wp_q   <= '0;
      rcnt_q <= '0;
      rp_q   <= '0;
      pend_q <= 1'b0;
      wovf_q <= 1'b0;
      rovf_q <= 1'b0;
    end else begin
      wsel_q <= wsel_d;
      wp_q   <= wp_d;
      rcnt_q <= rcnt_d;
      rp_q   <= rp_d;
      pend_q <= pend_d;
      wovf_q <= wovf_d;
      rovf_q <= rovf_d;
    end
  end

  // Bank contents are never cleared; rcnt alone decides what is readable.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_wsel][mem_waddr] <= bus.data_in;
  end

  always_comb begin
    bus.data_out = '0;
    bus.attr_out = '0;
    if (bus.oe) begin
      bus.attr_out[0] = ~rd_valid;
      bus.attr_out[1] = rovf_q;
      if (rd_valid) bus.data_out = rd_word;
    end
  end

  assign bus.words_ready = rcnt_q;
endmodule
